// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the memory arbiter slice.
//   ramstate_t  - status reported by the shared RAM each cycle
//   arb_state_t - arbiter grant state
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;
endpackage

// File: rtl/starve_counter.sv
// starve_counter: counts data grants served while an instruction fetch waits.
//   CLK, RST - clock, async active-high reset
//   inc      - one data hit while iREN pending (ignored once saturated)
//   clr      - clear (wins over inc)
//   sat      - count has reached MAX
module starve_counter #(
  parameter int MAX = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt;

  assign sat = (cnt == W'(MAX));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)               cnt <= '0;
    else if (clr)          cnt <= '0;
    else if (inc && !sat)  cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one shared RAM port between an instruction fetch
// port and a data load/store port. Data normally wins; after STARVE_MAX data
// hits with an instruction fetch pending, the fetch is granted next.
//   CLK, RST                    - clock, async active-high reset
//   iREN, iaddr / iwait, iload  - instruction request / response
//   dREN, dWEN, daddr, dstore   - data request
//   dwait, dload                - data response
//   ramREN, ramWEN, ramaddr,
//   ramstore / ramload, ramstate - shared RAM side
//   merr                        - sticky RAM error seen during a grant
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              merr
);
  arb_state_t st, nxt;
  ramstate_t  rs;
  logic       dreq, ihit, dhit, sat;

  assign rs   = ramstate_t'(ramstate);
  assign dreq = dREN || dWEN;
  // A hit needs the granted requester still asking; an ACCESS after
  // withdrawal just returns to IDLE.
  assign ihit = (st == IGRANT) && (rs == ACCESS) && iREN;
  assign dhit = (st == DGRANT) && (rs == ACCESS) && dreq;

  starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .CLK (CLK),
    .RST (RST),
    .inc (dhit && iREN),
    .clr (ihit || !iREN),
    .sat (sat)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) st <= IDLE;
    else     st <= nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                              merr <= 1'b0;
    else if ((st == IGRANT || st == DGRANT) && rs == ERROR) merr <= 1'b1;
  end

  always_comb begin
    nxt      = st;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (st)
      IDLE: begin
        if (iREN && sat) nxt = IGRANT;
        else if (dreq)   nxt = DGRANT;
        else if (iREN)   nxt = IGRANT;
      end
      IGRANT: begin
        // ERROR/BUSY/FREE keep the grant, so an errored access is retried.
        if (rs == ACCESS || !iREN) nxt = IDLE;
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      DGRANT: begin
        if (rs == ACCESS || !dreq) nxt = IDLE;
        // Simultaneous read+write is carried out as a write only.
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: nxt = IDLE;
    endcase
  end

  assign iwait = iREN && !(st == IGRANT && rs == ACCESS);
  assign dwait = dreq && !(st == DGRANT && rs == ACCESS);
  assign iload = ramload;
  assign dload = ramload;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  localparam int W    = 32;
  localparam int SMAX = 4;

  logic         CLK = 1'b0, RST;
  logic         iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN, merr;
  logic [W-1:0] iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
  logic [1:0]   ramstate;

  always #5 CLK = ~CLK;

  mem_arbiter #(.WORD_W(W), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic bad(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // Background contents of RAM words never written.
  function automatic logic [W-1:0] fill(logic [W-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  typedef struct packed {
    logic         wr;
    logic [W-1:0] a;
    logic [W-1:0] d;
  } dop_t;

  logic [W-1:0] ram_mem [logic [W-1:0]];  // what the RAM holds
  logic [W-1:0] ref_mem [logic [W-1:0]];  // what the program order says it should hold
  logic [W-1:0] iq[$];
  dop_t         dq[$];
  logic         mon_en = 1'b0, merr_exp = 1'b0, err_pend = 1'b0;
  int           streak = 0;

  // Monitor: pops expected results whenever a port is served.
  always @(negedge CLK) begin
    if (mon_en && !RST) begin
      chk1("merr", merr, merr_exp);
      chk1("dual_strobe", ramREN && ramWEN, 1'b0);
      if (!iREN) streak = 0;
      if (iREN && !iwait) begin
        if (iq.size() == 0) bad("iload_unexpected_hit");
        else chk("iload", iload, iq.pop_front());
        streak = 0;
      end
      if ((dREN || dWEN) && !dwait) begin
        if (iREN) begin
          streak++;
          chk1("starve_bound", streak <= SMAX, 1'b1);
        end
        if (dq.size() == 0) bad("data_unexpected_hit");
        else begin
          dop_t e;
          e = dq.pop_front();
          chk("d_ramaddr", ramaddr, e.a);
          if (e.wr) begin
            chk("d_ramstore", ramstore, e.d);
            chk1("d_ramWEN", ramWEN, 1'b1);
            chk1("d_ramREN_on_write", ramREN, 1'b0);
          end else begin
            chk("dload", dload, e.d);
          end
        end
      end
    end
  end

  task automatic rand_phase(int ncyc);
    bit ihit, dhit;
    int iage = 0, dage = 0, k, r;
    logic [W-1:0] a, d;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      ihit = iREN && !iwait;
      dhit = (dREN || dWEN) && !dwait;
      @(posedge CLK); #1;
      merr_exp = merr_exp | err_pend;
      err_pend = 1'b0;
      if (ihit) iREN = 1'b0;
      if (!iREN && $urandom_range(9) < 8) begin
        iREN  = 1'b1;
        iaddr = 32'h1000 + (32'($urandom_range(1023)) << 2);
        iq.push_back(fill(iaddr));
        iage = 0;
      end
      if (dhit) begin dREN = 1'b0; dWEN = 1'b0; end
      if (!dREN && !dWEN && $urandom_range(9) < 9) begin
        a = 32'h40 + (32'($urandom_range(7)) << 2);
        k = $urandom_range(3);
        daddr = a;
        if (k == 1 || k == 2) begin
          d = $urandom;
          dWEN = 1'b1;
          dREN = (k == 2);
          dstore = d;
          ref_mem[a] = d;
          dq.push_back('{1'b1, a, d});
        end else begin
          dREN = 1'b1;
          dstore = $urandom;
          dq.push_back('{1'b0, a, ref_mem.exists(a) ? ref_mem[a] : fill(a)});
        end
        dage = 0;
      end
      if (iREN) iage++;
      if (dREN || dWEN) dage++;
      if (iage > 200) begin bad("instr_timeout"); break; end
      if (dage > 200) begin bad("data_timeout"); break; end
      #1;
      if (ramREN || ramWEN) begin
        r = $urandom_range(99);
        ramstate = (r < 45) ? ACCESS : (r < 90) ? BUSY : (r < 95) ? ERROR : FREE;
      end else begin
        ramstate = FREE;
      end
      if (ramstate == ERROR) err_pend = 1'b1;
      ramload = ramREN ? (ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : fill(ramaddr))
                       : W'($urandom);
      if (ramstate == ACCESS && ramWEN) ram_mem[ramaddr] = ramstore;
    end
  endtask

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    repeat (2) @(negedge CLK);
    chk1("rst_ramREN", ramREN, 1'b0);
    chk1("rst_ramWEN", ramWEN, 1'b0);
    chk("rst_ramaddr", ramaddr, '0);
    chk("rst_ramstore", ramstore, '0);
    chk1("rst_merr", merr, 1'b0);
    chk1("rst_iwait", iwait, 1'b0);
    chk1("rst_dwait", dwait, 1'b0);
    RST = 1'b0;

    // Fetch, reset during IGRANT+BUSY, regrant, then hit after 2 BUSY cycles.
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h100; ramstate = BUSY;
    #1 chk1("idle_no_strobe", ramREN, 1'b0);
    chk1("idle_iwait", iwait, 1'b1);
    @(posedge CLK); #1;
    chk1("igrant_ramREN", ramREN, 1'b1);
    chk("igrant_ramaddr", ramaddr, 32'h100);
    #2 RST = 1'b1;
    #1 chk1("rst_mid_ramREN", ramREN, 1'b0);
    chk("rst_mid_ramaddr", ramaddr, '0);
    chk1("rst_mid_iwait", iwait, 1'b1);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    chk1("regrant_ramREN", ramREN, 1'b1);
    chk1("busy1_iwait", iwait, 1'b1);
    @(posedge CLK); #1;
    chk1("busy2_iwait", iwait, 1'b1);
    @(posedge CLK); #1;
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1 chk1("hit_iwait", iwait, 1'b0);
    chk("hit_iload", iload, 32'hDEADBEEF);

    // Fetch and store together: data first, fetch after the data hit.
    @(posedge CLK); #1;
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h40; dstore = 32'h12345678;
    ramstate = FREE;
    #1 chk1("gap_iwait", iwait, 1'b1);
    chk1("gap_ramREN", ramREN, 1'b0);
    @(posedge CLK); #1;
    chk1("dg_ramWEN", ramWEN, 1'b1);
    chk1("dg_ramREN", ramREN, 1'b0);
    chk("dg_ramaddr", ramaddr, 32'h40);
    chk("dg_ramstore", ramstore, 32'h12345678);
    ramstate = ACCESS;
    #1 chk1("dg_dwait", dwait, 1'b0);
    chk1("dg_iwait", iwait, 1'b1);
    @(posedge CLK); #1;
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    #1 chk1("gap2_ramREN", ramREN, 1'b0);
    @(posedge CLK); #1;
    chk1("ig2_ramREN", ramREN, 1'b1);
    chk("ig2_ramaddr", ramaddr, 32'h100);
    @(posedge CLK); #1;
    iREN = 1'b0;

    // Randomized traffic against the scoreboard.
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; merr_exp = 1'b0; mon_en = 1'b1;
    rand_phase(3000);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: WORD_W, 32, address/data width.
REQ-002 SHALL have parameter: STARVE_MAX, 4, consecutive data grants tolerated while iREN pending.
REQ-003 SHALL have port: CLK  in  1  single clock, rising edge.
REQ-004 SHALL have port: RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: iREN  in  1  instruction read request.
REQ-006 SHALL have port: iaddr  in  WORD_W  instruction address.
REQ-007 SHALL have port: iwait  out  1  instruction not yet served.
REQ-008 SHALL have port: iload  out  WORD_W  instruction data.
REQ-009 SHALL have ports: dREN, dWEN  in  1 each  data read/write request.
REQ-010 SHALL have ports: daddr, dstore  in  WORD_W each  data address/write data.
REQ-011 SHALL have port: dwait  out  1  data not yet served.
REQ-012 SHALL have port: dload  out  WORD_W  data read result.
REQ-013 SHALL have ports: ramREN, ramWEN  out  1 each  shared RAM strobes.
REQ-014 SHALL have ports: ramaddr, ramstore  out  WORD_W each  shared RAM address/write data.
REQ-015 SHALL have port: ramload  in  WORD_W  RAM read data.
REQ-016 SHALL have port: ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-017 SHALL have port: merr  out  1  sticky RAM error flag.

Function
REQ-018 SHALL implement registered FSM with states IDLE, IGRANT, DGRANT.
REQ-019 IDLE: iREN && starve_cnt==STARVE_MAX -> IGRANT; else (dREN||dWEN) -> DGRANT; else iREN -> IGRANT; else stay.
REQ-020 IGRANT/DGRANT: ramstate==ACCESS -> IDLE; granted request withdrawn -> IDLE; otherwise stay (BUSY, FREE, ERROR).
REQ-021 RAM outputs combinational from state and granted requester: IGRANT -> ramREN=iREN, ramaddr=iaddr; DGRANT -> ramWEN=dWEN, ramREN=dREN&&!dWEN, ramaddr=daddr, ramstore=dstore; IDLE -> all zero.
REQ-022 dREN&&dWEN together SHALL be performed as a write only.
REQ-023 iwait = iREN && !(IGRANT && ramstate==ACCESS); dwait = (dREN||dWEN) && !(DGRANT && ramstate==ACCESS).
REQ-024 iload and dload SHALL pass ramload combinationally; valid only in the hit cycle.
REQ-025 Latency: request seen in IDLE at edge n -> grant state at n+1; hit earliest in cycle n+1; one IDLE cycle between back-to-back transactions.
REQ-026 starve_cnt: +1 on each data hit while iREN high, saturating at STARVE_MAX; cleared on instruction hit or iREN low.
REQ-027 ERROR in a grant state SHALL set merr (held until reset) and retry the same access.
REQ-028 Requests changing mid-grant SHALL be reflected in RAM outputs the same cycle (no latching).

Reset
REQ-029 RST high SHALL force IDLE, starve_cnt=0, merr=0 immediately, hence ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-030 Reset mid-transaction SHALL abandon the access; no hit reported; after RST low arbitration restarts from IDLE.

Structure
REQ-031 ramstate_t and arb_state_t enums SHALL live in cpu_types_pkg.
REQ-032 Starvation counter SHALL be a sub-module starve_counter (inc, clr, sat output).

Verification
REQ-033 iREN=1, iaddr=0x100, RAM ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> iwait low exactly one cycle, iload=0xDEADBEEF.
REQ-034 iREN=1 and dWEN=1 from IDLE, daddr=0x40, dstore=0x12345678 -> DGRANT first, ramWEN=1 with those values; IGRANT after data hit.
REQ-035 iREN=1 and data requests reasserted continuously, RAM ACCESS every grant -> after 4 data hits next grant is IGRANT; starve_cnt returns to 0.
REQ-036 ramstate=ERROR for 1 cycle during DGRANT then ACCESS -> merr=1 and stays 1; dwait low on ACCESS cycle.
REQ-037 RST pulsed during IGRANT with ramstate=BUSY -> ramREN=0 same cycle, no iwait drop, iREN still high -> IGRANT one cycle after RST low.
REQ-038 dREN=dWEN=1 -> ramWEN=1, ramREN=0.
